core_mem_arbiter: RTL and testbench

Two-master Avalon-MM arbiter placed directly upstream of a core's single-port on-chip memory (13-bit word address, 32-bit data, 4 byte lanes, one-cycle read latency at the memory). It lets both Nios cores of the 2-core platform share one memory instance. It grants access round-robin, drives the memory's s1 command inputs, and returns registered read data to the issuing master with a `readdatavalid` strobe.

---
 rtl/core_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: two-master Avalon-MM round-robin arbiter in front of a
// single-port on-chip memory with one-cycle read latency. Read data returns
// to the issuing master two cycles after acceptance with a readdatavalid strobe.
// Optional feature: define CORE_MEM_ARB_LOCK_EN to add m0_lock/m1_lock, which
// let a master hold the grant across transfers.

module core_mem_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
`ifdef CORE_MEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  // memory s1 command / response
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic accept;
  logic acc_id;
  logic acc_write;

  // last_grant_q = 1 means m1 was granted last, so m0 wins the next contention
  logic last_grant_q;

  // stage 1: the read the memory is answering this cycle
  logic rsp_vld_q;
  logic rsp_id_q;

  // stage 2: per-master data register and strobe
  logic              rdv0_q, rdv1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifdef CORE_MEM_ARB_LOCK_EN
  logic own_vld_q;
  logic own_id_q;
  logic acc_lock;
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Eligibility: a lock owner excludes the other master even when idle
  always_comb begin
    elig0 = req0;
    elig1 = req1;
`ifdef CORE_MEM_ARB_LOCK_EN
    if (own_vld_q) begin
      if (own_id_q) begin
        elig0 = 1'b0;
      end else begin
        elig1 = 1'b0;
      end
    end
`endif
  end

  // Round-robin grant; nothing is granted while reset is asserted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign accept    = grant0 | grant1;
  assign acc_id    = grant1;
  // read+write together counts as a write
  assign acc_write = grant1 ? m1_write : m0_write;

`ifdef CORE_MEM_ARB_LOCK_EN
  assign acc_lock = grant1 ? m1_lock : m0_lock;
`endif

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  // Memory command mux; idle cycles present m0's fields
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    mem_chipselect = accept;
    mem_write      = accept & acc_write;
  end

  assign mem_clken = 1'b1;

  // Round-robin history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= acc_id;
    end
  end

  // Stage 1: track an accepted read while the memory produces its data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      rsp_vld_q <= accept & ~acc_write;
      rsp_id_q  <= acc_id;
    end
  end

  // Stage 2: capture memory data for master 0 and strobe once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv0_q   <= 1'b0;
      rdata0_q <= '0;
    end else begin
      rdv0_q <= rsp_vld_q & ~rsp_id_q;
      if (rsp_vld_q && !rsp_id_q) begin
        rdata0_q <= mem_readdata;
      end
    end
  end

  // Stage 2: capture memory data for master 1 and strobe once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv1_q   <= 1'b0;
      rdata1_q <= '0;
    end else begin
      rdv1_q <= rsp_vld_q & rsp_id_q;
      if (rsp_vld_q && rsp_id_q) begin
        rdata1_q <= mem_readdata;
      end
    end
  end

  assign m0_readdata      = rdata0_q;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdata      = rdata1_q;
  assign m1_readdatavalid = rdv1_q;

`ifdef CORE_MEM_ARB_LOCK_EN
  // Lock ownership follows the lock bit of every accepted transfer; only the
  // owner can be accepted while it holds the lock, so an unlocked transfer
  // by the owner releases it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_vld_q <= 1'b0;
      own_id_q  <= 1'b0;
    end else if (accept) begin
      own_vld_q <= acc_lock;
      own_id_q  <= acc_id;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: a memory model on the s1 side, a
// reference model that predicts grants and read responses from the arbitration
// rules, and directed scenarios with literal expectations.

module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        m0_lock, m1_lock;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes0 = 0;
  int strobes1 = 0;

  always #5 clk = ~clk;

  core_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef CORE_MEM_ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
`endif
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  function automatic logic [31:0] init_word(int a);
    if (a == 'h0010) return 32'hDEADBEEF;
    if (a == 'h1FFF) return 32'hAAAAAAAA;
    return {16'hC0DE, 3'b000, a[12:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Memory model: one-cycle read latency, byte-lane writes
  logic [31:0] tb_mem [0:8191];
  initial begin
    for (int a = 0; a < 8192; a++) tb_mem[a] = init_word(a);
    mem_readdata = '0;
    forever begin
      @(posedge clk);
      if (mem_chipselect && mem_clken) begin
        if (mem_write) begin
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) tb_mem[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        end else begin
          mem_readdata <= tb_mem[mem_address];
        end
      end
    end
  end

  // Reference model and per-cycle compare
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } rsp_t;

  initial begin
    logic [31:0] ref_mem [0:8191];
    rsp_t        q[$];
    rsp_t        e;
    bit          lg, own_v, own_id;
    bit          r0, r1, e0, e1, g0, g1, ev0, ev1, wr;
    logic [31:0] erd0, erd1, wd;
    logic [12:0] ad;
    logic [3:0]  be;
    for (int a = 0; a < 8192; a++) ref_mem[a] = init_word(a);
    lg = 1'b1; own_v = 1'b0; own_id = 1'b0; erd0 = '0; erd1 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        q.delete();
        lg = 1'b1; own_v = 1'b0; erd0 = '0; erd1 = '0;
      end
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      e0 = r0; e1 = r1;
`ifdef CORE_MEM_ARB_LOCK_EN
      if (own_v) begin
        if (own_id) e0 = 1'b0; else e1 = 1'b0;
      end
`endif
      // both contending: the master that was not granted last wins
      g0 = reset_n && e0 && (!e1 || lg);
      g1 = reset_n && e1 && !g0;
      ev0 = 1'b0; ev1 = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.id) begin ev1 = 1'b1; erd1 = e.data; end
        else begin ev0 = 1'b1; erd0 = e.data; end
      end
      wr = g1 ? m1_write : m0_write;
      ad = g1 ? m1_address : m0_address;
      be = g1 ? m1_byteenable : m0_byteenable;
      wd = g1 ? m1_writedata : m0_writedata;
      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(!g0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(!g1));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(g0 | g1));
      chk("mem_write", 32'(mem_write), 32'((g0 | g1) & wr));
      chk("mem_address", 32'(mem_address), 32'(ad));
      chk("mem_clken", 32'(mem_clken), 32'd1);
      if (mem_write) begin
        chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
        chk("mem_writedata", mem_writedata, wd);
      end
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ev0));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ev1));
      chk("m0_readdata", m0_readdata, erd0);
      chk("m1_readdata", m1_readdata, erd1);
      if (m0_readdatavalid) strobes0++;
      if (m1_readdatavalid) strobes1++;
      // commit the transfer that the coming edge accepts
      if (g0 || g1) begin
        lg = g1;
        own_v = g1 ? m1_lock : m0_lock;
        own_id = g1;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
        end else begin
          e.due = cyc + 2; e.id = g1; e.data = ref_mem[ad];
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_lock = 0; m1_lock = 0;
  endtask

  // Directed stimulus with literal expectations
  initial begin
    reset_n = 1'b0;
    idle_all();
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    #2;
    chk("rst m0_readdata", m0_readdata, 32'h0);
    chk("rst m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    chk("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // single read by m0
    m0_read = 1; m0_address = 13'h0010;
    #2 chk("single grant", 32'(m0_waitrequest), 32'd0);
    tick();
    idle_all();
    tick();
    #2;
    chk("single rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("single data", m0_readdata, 32'hDEADBEEF);
    chk("single rdv1", 32'(m1_readdatavalid), 32'd0);
    tick();

    // m1 partial write then read-back
    m1_write = 1; m1_address = 13'h1FFF; m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
    tick();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    tick();
    idle_all();
    tick();
    #2;
    chk("wr-rd rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("wr-rd data", m1_readdata, 32'hAAAA5678);
    tick();

    // continuous contention: strict alternation starting with m0
    strobes0 = 0; strobes1 = 0;
    m0_read = 1; m0_address = 13'h0020;
    m1_read = 1; m1_address = 13'h0030;
    for (int i = 0; i < 8; i++) begin
      #2 chk("alt m0_waitrequest", 32'(m0_waitrequest), 32'(i % 2));
      tick();
    end
    idle_all();
    tick(); tick(); tick();
    chk("alt strobes m0", 32'(strobes0), 32'd4);
    chk("alt strobes m1", 32'(strobes1), 32'd4);
    chk("alt data m0", m0_readdata, 32'hC0DE0020);
    chk("alt data m1", m1_readdata, 32'hC0DE0030);

    // read and write together behave as a write
    strobes0 = 0;
    m0_read = 1; m0_write = 1; m0_address = 13'h0004;
    m0_writedata = 32'h00000055; m0_byteenable = 4'hF;
    tick();
    idle_all();
    tick(); tick(); tick();
    chk("rw no strobe", 32'(strobes0), 32'd0);
    chk("rw mem", tb_mem[4], 32'h00000055);

    // reset while a read is in flight
    strobes0 = 0;
    m0_read = 1; m0_address = 13'h0010;
    tick();
    reset_n = 1'b0;
    #2;
    chk("mid-rst m0_readdata", m0_readdata, 32'h0);
    chk("mid-rst waitrequest", 32'(m0_waitrequest), 32'd1);
    chk("mid-rst chipselect", 32'(mem_chipselect), 32'd0);
    tick();
    reset_n = 1'b1;
    m1_read = 1; m1_address = 13'h0030;
    #2 chk("post-rst m0 wins", 32'(m0_waitrequest), 32'd0);
    tick();
    idle_all();
    tick(); tick(); tick();
    chk("post-rst strobes m0", 32'(strobes0), 32'd1);
    chk("post-rst data m0", m0_readdata, 32'hDEADBEEF);

`ifdef CORE_MEM_ARB_LOCK_EN
    // locked write by m1 holds the grant while m1 idles
    m1_write = 1; m1_lock = 1; m1_address = 13'h0040; m1_writedata = 32'h0BADF00D;
    tick();
    idle_all();
    m0_read = 1; m0_address = 13'h0010;
    for (int i = 0; i < 3; i++) begin
      #2 chk("lock m0 held", 32'(m0_waitrequest), 32'd1);
      tick();
    end
    m1_write = 1; m1_lock = 0;
    #2 chk("lock owner unlocks", 32'(m1_waitrequest), 32'd0);
    tick();
    m1_write = 0;
    #2 chk("lock m0 released", 32'(m0_waitrequest), 32'd0);
    tick();
    idle_all();
    tick(); tick();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
